// File: rtl/mem_aa_demux.sv
// Receive side of the multiplexed DRAM address bus: rebuilds 20-bit LBD addresses from RAS/CAS halves.
// Optional CAS-before-RAS refresh decoding is enabled by defining MEM_AA_DEMUX_CBR_EN.
module mem_aa_demux #(
  parameter logic [15:0] RAS_MAX = 16'd1000
) (
  input  logic        sysclk,
  input  logic        sys_rst,
  input  logic [9:0]  AA_9_0,
  input  logic        RAS_n,
  input  logic        CAS_n,
  input  logic        WE_n,
  output logic [19:0] ADDR_19_0,
  output logic        ADDR_STB,
  output logic        ADDR_WE,
  output logic        PAGE_HIT,
  output logic        REFRESH_STB,
  output logic [9:0]  REF_ROW,
  output logic        RAS_TMO,
  output logic        PROTO_ERR
);

  // state      | meaning
  // IDLE       | both strobes idle, waiting for RAS or CAS fall
  // ROW_OPEN   | row latched, waiting for a CAS fall or RAS rise
  // COL_ACTIVE | column strobe low, waiting for CAS rise or RAS rise
  // CBR_PEND   | CAS fell first, waiting for RAS fall (CBR refresh)
  // CBR        | CBR refresh in progress, waiting for both strobes high
  typedef enum logic [2:0] {IDLE, ROW_OPEN, COL_ACTIVE, CBR_PEND, CBR} state_t;

  state_t      state_q, state_d;
  logic        ras_prev_q, cas_prev_q;
  logic        ras_arm_q, ras_arm_d, cas_arm_q, cas_arm_d;
  logic [9:0]  row_q, row_d;
  logic        col_seen_q, col_seen_d;
  logic [19:0] addr_q, addr_d;
  logic        addr_stb_q, addr_stb_d;
  logic        addr_we_q, addr_we_d;
  logic        page_hit_q, page_hit_d;
  logic        ref_stb_q, ref_stb_d;
  logic [9:0]  ref_row_q, ref_row_d;
  logic        tmo_q, tmo_d;
  logic        perr_q, perr_d;
  logic [15:0] ras_cnt_q, ras_cnt_d;

  logic ras_fall, ras_rise, cas_fall, cas_rise;

  // A strobe held low through reset must be seen high before its fall counts.
  assign ras_fall = ras_arm_q & ras_prev_q & ~RAS_n;
  assign cas_fall = cas_arm_q & cas_prev_q & ~CAS_n;
  assign ras_rise = ~ras_prev_q & RAS_n;
  assign cas_rise = ~cas_prev_q & CAS_n;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_seen_d = col_seen_q;
    addr_d     = addr_q;
    addr_stb_d = 1'b0;
    addr_we_d  = addr_we_q;
    page_hit_d = page_hit_q;
    ref_stb_d  = 1'b0;
    ref_row_d  = ref_row_q;
    perr_d     = perr_q;
    ras_arm_d  = ras_arm_q | RAS_n;
    cas_arm_d  = cas_arm_q | CAS_n;

    case (state_q)
      IDLE: begin
        if (ras_fall && cas_fall) begin
          perr_d = 1'b1;
        end else if (ras_fall && CAS_n) begin
          row_d      = AA_9_0;
          col_seen_d = 1'b0;
          state_d    = ROW_OPEN;
        end else if (cas_fall && RAS_n) begin
`ifdef MEM_AA_DEMUX_CBR_EN
          state_d = CBR_PEND;
`else
          perr_d  = 1'b1;
`endif
        end
      end
      ROW_OPEN, COL_ACTIVE: begin
        if (ras_rise) begin
          if (!col_seen_q) begin
            ref_stb_d = 1'b1;
            ref_row_d = row_q;
          end
          state_d = IDLE;
        end else if (state_q == ROW_OPEN && cas_fall) begin
          addr_d     = {AA_9_0[9], row_q[9], AA_9_0[8:0], row_q[8:0]};
          addr_we_d  = ~WE_n;
          addr_stb_d = 1'b1;
          page_hit_d = col_seen_q;
          col_seen_d = 1'b1;
          state_d    = COL_ACTIVE;
        end else if (state_q == COL_ACTIVE && cas_rise) begin
          state_d = ROW_OPEN;
        end
      end
`ifdef MEM_AA_DEMUX_CBR_EN
      CBR_PEND: begin
        if (ras_fall) begin
          ref_stb_d = 1'b1;
          ref_row_d = 10'd0;
          state_d   = CBR;
        end else if (cas_rise) begin
          perr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      CBR: begin
        if (RAS_n && CAS_n) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Timeout counter saturates so the flag stays meaningful on very long RAS.
  always_comb begin
    if (RAS_n)                  ras_cnt_d = 16'd0;
    else if (ras_cnt_q >= RAS_MAX) ras_cnt_d = ras_cnt_q;
    else                        ras_cnt_d = ras_cnt_q + 16'd1;
    tmo_d = tmo_q | (~RAS_n & (ras_cnt_d == RAS_MAX));
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      ras_prev_q <= 1'b1;
      cas_prev_q <= 1'b1;
      ras_arm_q  <= RAS_n;
      cas_arm_q  <= CAS_n;
      row_q      <= 10'd0;
      col_seen_q <= 1'b0;
      addr_q     <= 20'd0;
      addr_stb_q <= 1'b0;
      addr_we_q  <= 1'b0;
      page_hit_q <= 1'b0;
      ref_stb_q  <= 1'b0;
      ref_row_q  <= 10'd0;
      tmo_q      <= 1'b0;
      perr_q     <= 1'b0;
      ras_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      ras_prev_q <= RAS_n;
      cas_prev_q <= CAS_n;
      ras_arm_q  <= ras_arm_d;
      cas_arm_q  <= cas_arm_d;
      row_q      <= row_d;
      col_seen_q <= col_seen_d;
      addr_q     <= addr_d;
      addr_stb_q <= addr_stb_d;
      addr_we_q  <= addr_we_d;
      page_hit_q <= page_hit_d;
      ref_stb_q  <= ref_stb_d;
      ref_row_q  <= ref_row_d;
      tmo_q      <= tmo_d;
      perr_q     <= perr_d;
      ras_cnt_q  <= ras_cnt_d;
    end
  end

  assign ADDR_19_0   = addr_q;
  assign ADDR_STB    = addr_stb_q;
  assign ADDR_WE     = addr_we_q;
  assign PAGE_HIT    = page_hit_q;
  assign REFRESH_STB = ref_stb_q;
  assign REF_ROW     = ref_row_q;
  assign RAS_TMO     = tmo_q;
  assign PROTO_ERR   = perr_q;

endmodule
